seq_detector_prog: RTL and testbench
====================================

// Module: seq_detector_prog
// PURPOSE
//  Parametrised serial bit-pattern detector: next generation of the lab FSM detector.
//  Pattern length and reset pattern are parameters; the pattern is reloadable at run time.
//  Selectable overlap/non-overlap matching, input-valid qualifier and a saturating match counter.
//  Sits on a 1-bit serial stream; outp pulses one cycle per detected pattern.
// PARAMETERS
//  PAT_LEN   5         pattern length in bits, legal 2..32
//  PATTERN   5'b10110  pattern loaded at reset; first-received bit = MSB
//  OVERLAP   1         1: overlapping matches allowed; 0: history restarts after a match
//  CNT_W     8         width of match counter, legal 1..32
// PORTS
//  clk        in   1        clock, all state updates on rising edge
//  rst        in   1        synchronous reset, active-high
//  en         in   1        inp is valid this cycle; when 0, nothing is sampled
//  inp        in   1        serial data bit
//  pat_load   in   1        load pat_in as the new pattern
//  pat_in     in   PAT_LEN  new pattern (MSB = first bit of sequence)
//  outp       out  1        one-cycle match pulse, registered
//  match_cnt  out  CNT_W    number of matches since reset/load, saturating
//  cnt_sat    out  1        high while match_cnt is all ones
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high (clk, rst).
//  - Reset (rst=1 at edge):
//    - pat_reg <= PATTERN, hist <= 0, fill <= 0
//    - outp <= 0, match_cnt <= 0, cnt_sat <= 0
//    - rst overrides pat_load and en.
//  - Internal state:
//    - hist: PAT_LEN-bit shift register, newest bit in LSB.
//    - fill: count of valid history bits, width $clog2(PAT_LEN+1), saturates at PAT_LEN.
//  - Priority each edge: rst > pat_load > en.
//  - pat_load=1:
//    - pat_reg <= pat_in, hist <= 0, fill <= 0, outp <= 0, match_cnt <= 0.
//    - inp is ignored in that cycle.
//  - en=1 (no load):
//    - nh = {hist[PAT_LEN-2:0], inp}; hist <= nh.
//    - A match is (fill >= PAT_LEN-1) && (nh == pat_reg).
//    - fill gating prevents false matches on the zeroed history after reset.
//  - On a match:
//    - outp <= 1, so outp is high in the cycle after the edge that sampled the last bit (latency 1).
//    - match_cnt <= match_cnt+1 unless already all ones, where it holds.
//    - OVERLAP=1: fill stays at PAT_LEN; the next match may come as soon as the pattern's period permits.
//    - OVERLAP=0: fill <= 0, so the next match needs PAT_LEN fresh bits.
//  - No match with en=1: outp <= 0; fill <= min(fill+1, PAT_LEN).
//  - en=0: hist, fill and match_cnt hold; outp <= 0, so a pulse never stretches.
//  - cnt_sat is registered: high in the same cycle match_cnt first reads all ones.
//  - Outputs are fully registered; no combinational path from inputs to outputs.
//  - Reset mid-sequence discards the partial history; a pattern in flight is not detected.
// TESTING
//  1. Reset, OVERLAP=1, default pattern; en=1, inp=1,0,1,1,0,1,1,0
//     -> outp pulses after bits 5 and 8; match_cnt=2.
//  2. Same stream, OVERLAP=0
//     -> a single pulse after bit 5; match_cnt=1.
//  3. pat_load with pat_in=5'b00000, then four 0s
//     -> no pulse; fifth 0 -> pulse; each further 0 -> pulse (OVERLAP=1).
//  4. Default pattern with en toggled 0 between every bit of 10110
//     -> one pulse one cycle after the final sampled 0; outp never high while en=0.
//  5. CNT_W=2, six matches
//     -> match_cnt sequence 1,2,3,3,3,3; cnt_sat high from the third match on.
//  6. rst asserted after 1011 fed; then 0,1,0,1,1,0
//     -> no pulse on the first 0; a pulse only after the trailing 10110.

Source files
------------

// File: rtl/seq_detector_prog.sv
// Programmable serial bit-pattern detector with run-time pattern reload,
// selectable overlap/non-overlap matching, an input-valid qualifier and a
// saturating match counter. All outputs are registered.
module seq_detector_prog #(
  parameter int unsigned         PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0]  PATTERN = 5'b10110,
  parameter bit                  OVERLAP = 1'b1,
  parameter int unsigned         CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               inp,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  output logic               outp,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  localparam int unsigned        FILL_W   = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0]  FILL_THR = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] pat_q,  pat_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               outp_q, outp_d;
  logic [CNT_W-1:0]   cnt_q,  cnt_d;
  logic               sat_q,  sat_d;

  logic [PAT_LEN-1:0] nh;
  logic               hit;

  // Next-state logic: pattern load takes precedence over sampling a bit.
  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    outp_d = 1'b0;
    cnt_d  = cnt_q;
    nh     = {hist_q[PAT_LEN-2:0], inp};
    // Needs PAT_LEN valid bits including the one arriving now.
    hit    = (fill_q >= FILL_THR) && (nh == pat_q);
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (en) begin
      hist_d = nh;
      if (hit) begin
        outp_d = 1'b1;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Overlap keeps the full window valid; non-overlap demands fresh bits.
        fill_d = OVERLAP ? FILL_MAX : '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
    // Saturation flag tracks the registered counter value it accompanies.
    sat_d = (cnt_d == '1);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      outp_q <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      outp_q <= outp_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign outp      = outp_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog: three instances (overlap with
// 8-bit counter, non-overlap, overlap with 2-bit counter) share one stimulus
// stream; a reference model predicts every cycle's outputs into a queue and
// a negedge monitor pops and compares.
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       rst, en, inp, pat_load;
  logic [4:0] pat_in;
  logic       oa, ob, oc, sa, sb, sc;
  logic [7:0] ca, cb;
  logic [1:0] cc;

  seq_detector_prog #(.PAT_LEN(5), .PATTERN(5'b10110), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .inp(inp), .pat_load(pat_load), .pat_in(pat_in),
    .outp(oa), .match_cnt(ca), .cnt_sat(sa));
  seq_detector_prog #(.PAT_LEN(5), .PATTERN(5'b10110), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .inp(inp), .pat_load(pat_load), .pat_in(pat_in),
    .outp(ob), .match_cnt(cb), .cnt_sat(sb));
  seq_detector_prog #(.PAT_LEN(5), .PATTERN(5'b10110), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .en(en), .inp(inp), .pat_load(pat_load), .pat_in(pat_in),
    .outp(oc), .match_cnt(cc), .cnt_sat(sc));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] o;
    logic [2:0] s;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [1:0] c2;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: recent bits of the stream plus, per instance, how many
  // bits have arrived since the last restart (reset, load, or non-overlap hit).
  bit [4:0] m_pat;
  bit       stream[$];
  int       since[3];
  int       cnt[3];
  int       cmax[3] = '{255, 255, 3};
  bit       ovl[3]  = '{1'b1, 1'b0, 1'b1};

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit ld, input bit e, input bit b,
                              input bit [4:0] p);
    exp_t     x;
    bit [2:0] o = '0;
    bit [4:0] last;
    if (r || ld) begin
      m_pat = r ? 5'b10110 : p;
      stream.delete();
      for (int i = 0; i < 3; i++) begin since[i] = 0; cnt[i] = 0; end
    end else if (e) begin
      stream.push_back(b);
      if (stream.size() > 5) void'(stream.pop_front());
      last = '0;
      for (int k = 0; k < stream.size(); k++) last = {last[3:0], stream[k]};
      for (int i = 0; i < 3; i++) begin
        if (since[i] < 5) since[i]++;
        if (since[i] >= 5 && last == m_pat) begin
          o[i] = 1'b1;
          if (cnt[i] < cmax[i]) cnt[i]++;
          if (!ovl[i]) since[i] = 0;
        end
      end
    end
    x.o  = o;
    x.s  = {cnt[2] == cmax[2], cnt[1] == cmax[1], cnt[0] == cmax[0]};
    x.c0 = 8'(cnt[0]);
    x.c1 = 8'(cnt[1]);
    x.c2 = 2'(cnt[2]);
    sbq.push_back(x);
  endtask

  task automatic step(input bit r, input bit ld, input bit e, input bit b,
                      input bit [4:0] p);
    rst = r; pat_load = ld; en = e; inp = b; pat_in = p;
    @(posedge clk);
    model_update(r, ld, e, b, p);
    #1;
  endtask

  task automatic feed(input bit [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, v[i], 5'd0);
  endtask

  // Monitor: every edge yields one registered output set to compare.
  always @(negedge clk) begin
    exp_t x;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      chk("outp_a", int'(oa), int'(x.o[0]));
      chk("outp_b", int'(ob), int'(x.o[1]));
      chk("outp_c", int'(oc), int'(x.o[2]));
      chk("cnt_a",  int'(ca), int'(x.c0));
      chk("cnt_b",  int'(cb), int'(x.c1));
      chk("cnt_c",  int'(cc), int'(x.c2));
      chk("sat_a",  int'(sa), int'(x.s[0]));
      chk("sat_b",  int'(sb), int'(x.s[1]));
      chk("sat_c",  int'(sc), int'(x.s[2]));
    end
  end

  initial begin
    bit [4:0] pats[4] = '{5'b10110, 5'b00000, 5'b10101, 5'b11111};
    int       w;
    rst = 1'b1; en = 1'b0; inp = 1'b0; pat_load = 1'b0; pat_in = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);

    // Overlapping vs non-overlapping on 1,0,1,1,0,1,1,0
    feed(32'b10110110, 8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    chk("t1_cnt_overlap", int'(ca), 2);
    chk("t1_cnt_nonoverlap", int'(cb), 1);

    // All-zero pattern: fill gating, then saturation of the 2-bit counter
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'b00000);
    feed(32'b0, 8);
    @(negedge clk);
    chk("t3_cnt_a", int'(ca), 4);
    chk("t3_cnt_b", int'(cb), 1);
    chk("t3_cnt_c", int'(cc), 3);
    chk("t3_sat_c", int'(sc), 1);

    // en toggled between every bit
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int i = 4; i >= 0; i--) begin
      w = 32'b10110;
      step(1'b0, 1'b0, 1'b1, w[i], 5'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    end

    // Reset mid-sequence discards partial history
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    feed(32'b1011, 4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    feed(32'b010110, 6);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    chk("t6_cnt_a", int'(ca), 1);

    // Randomised traffic with occasional reloads and resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0)
        step(1'b1, 1'b0, 1'($urandom), 1'($urandom), 5'd0);
      else if ($urandom_range(0, 99) == 0)
        step(1'b0, 1'b1, 1'($urandom), 1'($urandom), pats[$urandom_range(0, 3)]);
      else
        step(1'b0, 1'b0, ($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom));
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

    w = 0;
    while (sbq.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    #1;
    chk("scoreboard_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
